// File: rtl/sig_cond_pkg.sv
// Shared constants and helpers for the signal-conditioning blocks.
package sig_cond_pkg;

  localparam int DEF_NUM_CH      = 8;
  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_CNT_W       = 20;

  // Channel-index width; never narrower than one bit so NUM_CH=1 still works.
  function automatic int ch_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debounced input: synchroniser, candidate/counter filter, clean level and edge strobes.
module debounce_channel
  import sig_cond_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int CNT_W       = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             noisy_in,
  input  logic             enable,
  input  logic [CNT_W-1:0] threshold,
  output logic             clean_out,
  output logic             rise_pulse,
  output logic             fall_pulse
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   sync_in;
  logic                   cand_q, cand_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   en_q, en_d;
  logic                   clean_q, clean_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;

  assign sync_in = sync_q[SYNC_STAGES-1];

  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], noisy_in};
    cand_d  = cand_q;
    cnt_d   = cnt_q;
    en_d    = enable;
    clean_d = clean_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    if (sync_in != cand_q) begin
      cand_d = sync_in;
      cnt_d  = '0;
    end else if (!enable || !en_q) begin
      // First enabled cycle also restarts from zero, so re-enable costs threshold+2.
      cnt_d = '0;
    end else if (cnt_q < threshold) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = threshold;
      if (clean_q != cand_q) begin
        clean_d = cand_q;
        rise_d  = cand_q;
        fall_d  = !cand_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q  <= '0;
      cand_q  <= 1'b0;
      cnt_q   <= '0;
      en_q    <= 1'b0;
      clean_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      cand_q  <= cand_d;
      cnt_q   <= cnt_d;
      en_q    <= en_d;
      clean_q <= clean_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign clean_out  = clean_q;
  assign rise_pulse = rise_q;
  assign fall_pulse = fall_q;

endmodule

// File: rtl/multi_channel_debouncer.sv
// Array of debounced channels feeding a round-robin change-event stream with overflow tracking.
module multi_channel_debouncer
  import sig_cond_pkg::*;
#(
  parameter  int NUM_CH      = DEF_NUM_CH,
  parameter  int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter  int CNT_W       = DEF_CNT_W,
  localparam int CH_W        = ch_idx_w(NUM_CH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_CH-1:0] noisy_in,
  input  logic [NUM_CH-1:0] ch_enable,
  input  logic [CNT_W-1:0]  cfg_threshold,
  output logic [NUM_CH-1:0] clean_out,
  output logic [NUM_CH-1:0] rise_pulse,
  output logic [NUM_CH-1:0] fall_pulse,
  output logic              evt_valid,
  input  logic              evt_ready,
  output logic [CH_W-1:0]   evt_ch,
  output logic              evt_level,
  output logic [NUM_CH-1:0] ovf_flags,
  input  logic [NUM_CH-1:0] ovf_clear
);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    debounce_channel #(
      .SYNC_STAGES(SYNC_STAGES),
      .CNT_W      (CNT_W)
    ) u_ch (
      .clk       (clk),
      .reset     (reset),
      .noisy_in  (noisy_in[i]),
      .enable    (ch_enable[i]),
      .threshold (cfg_threshold),
      .clean_out (clean_out[i]),
      .rise_pulse(rise_pulse[i]),
      .fall_pulse(fall_pulse[i])
    );
  end

  logic [NUM_CH-1:0] pend_q, pend_d;
  logic [NUM_CH-1:0] lvl_q, lvl_d;
  logic [NUM_CH-1:0] ovf_q, ovf_d;
  logic              evt_valid_q, evt_valid_d;
  logic [CH_W-1:0]   evt_ch_q, evt_ch_d;
  logic              evt_level_q, evt_level_d;
  logic [CH_W-1:0]   last_q, last_d;

  logic              hs, load, found;
  logic [NUM_CH-1:0] chg, hs_vec, avail;
  logic [CH_W-1:0]   gnt;
  int                idx;

  always_comb begin
    hs     = evt_valid_q && evt_ready;
    chg    = rise_pulse | fall_pulse;
    hs_vec = hs ? (NUM_CH'(1) << evt_ch_q) : '0;
    pend_d = pend_q;
    lvl_d  = lvl_q;
    ovf_d  = ovf_q & ~ovf_clear;
    for (int i = 0; i < NUM_CH; i++) begin
      if (hs_vec[i]) pend_d[i] = 1'b0;
      // A change landing on the handshake cycle re-arms pending without counting as lost.
      if (chg[i]) begin
        pend_d[i] = 1'b1;
        lvl_d[i]  = clean_out[i];
        if (pend_q[i] && !hs_vec[i]) ovf_d[i] = 1'b1;
      end
    end

    avail = pend_q & ~hs_vec;
    load  = !evt_valid_q || hs;
    found = 1'b0;
    gnt   = '0;
    idx   = 0;
    for (int k = 0; k < NUM_CH; k++) begin
      idx = int'(last_q) + 1 + k;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      if (!found && avail[idx]) begin
        found = 1'b1;
        gnt   = CH_W'(idx);
      end
    end

    evt_valid_d = evt_valid_q;
    evt_ch_d    = evt_ch_q;
    evt_level_d = evt_level_q;
    last_d      = last_q;
    if (load) begin
      evt_valid_d = found;
      if (found) begin
        evt_ch_d    = gnt;
        evt_level_d = lvl_q[gnt];
        last_d      = gnt;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pend_q      <= '0;
      lvl_q       <= '0;
      ovf_q       <= '0;
      evt_valid_q <= 1'b0;
      evt_ch_q    <= '0;
      evt_level_q <= 1'b0;
      last_q      <= CH_W'(NUM_CH - 1);
    end else begin
      pend_q      <= pend_d;
      lvl_q       <= lvl_d;
      ovf_q       <= ovf_d;
      evt_valid_q <= evt_valid_d;
      evt_ch_q    <= evt_ch_d;
      evt_level_q <= evt_level_d;
      last_q      <= last_d;
    end
  end

  assign evt_valid = evt_valid_q;
  assign evt_ch    = evt_ch_q;
  assign evt_level = evt_level_q;
  assign ovf_flags = ovf_q;

endmodule

// File: tb/tb_multi_channel_debouncer.sv
// Directed bench for multi_channel_debouncer with an event scoreboard.
module tb_multi_channel_debouncer;

  localparam int NUM_CH      = 8;
  localparam int SYNC_STAGES = 2;
  localparam int CNT_W       = 20;
  localparam int CH_W        = 3;

  logic              clk = 1'b0;
  logic              reset;
  logic [NUM_CH-1:0] noisy_in;
  logic [NUM_CH-1:0] ch_enable;
  logic [CNT_W-1:0]  cfg_threshold;
  logic [NUM_CH-1:0] clean_out, rise_pulse, fall_pulse;
  logic              evt_valid, evt_ready, evt_level;
  logic [CH_W-1:0]   evt_ch;
  logic [NUM_CH-1:0] ovf_flags, ovf_clear;

  multi_channel_debouncer #(
    .NUM_CH(NUM_CH), .SYNC_STAGES(SYNC_STAGES), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset), .noisy_in(noisy_in), .ch_enable(ch_enable),
    .cfg_threshold(cfg_threshold), .clean_out(clean_out), .rise_pulse(rise_pulse),
    .fall_pulse(fall_pulse), .evt_valid(evt_valid), .evt_ready(evt_ready),
    .evt_ch(evt_ch), .evt_level(evt_level), .ovf_flags(ovf_flags), .ovf_clear(ovf_clear)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [CH_W-1:0] ch;
    logic            level;
  } ev_t;

  ev_t exp_q[$];
  int  n_cmp = 0;
  int  n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int ch, input logic lvl);
    ev_t e;
    e.ch    = CH_W'(ch);
    e.level = lvl;
    exp_q.push_back(e);
  endtask

  // One clock: handshakes are scored mid-cycle, then step to just past the edge.
  task automatic cyc();
    ev_t e;
    @(negedge clk);
    if (!reset && evt_valid && evt_ready) begin
      n_cmp++;
      assert (exp_q.size() != 0) else begin
        n_err++;
        $error("FAIL evt_unexpected: observed ch=%0d level=%0b expected no event", evt_ch, evt_level);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("evt_ch", 64'(evt_ch), 64'(e.ch));
        chk("evt_level", 64'(evt_level), 64'(e.level));
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic cycn(input int n);
    repeat (n) cyc();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cycn(2);
    exp_q.delete();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; noisy_in = '0; ch_enable = '1; cfg_threshold = 20'd10;
    evt_ready = 1'b1; ovf_clear = '0;
    cycn(2);
    chk("rst_clean", 64'(clean_out), 0);
    chk("rst_pulses", 64'({rise_pulse, fall_pulse}), 0);
    chk("rst_evt_valid", 64'(evt_valid), 0);
    chk("rst_ovf", 64'(ovf_flags), 0);
    reset = 1'b0;

    // ch2 step up and back down, threshold 10: accept 14 cycles after the pin
    noisy_in[2] = 1'b1; push(2, 1'b1);
    cycn(13);
    chk("ch2_rise_early", 64'(clean_out[2]), 0);
    cyc();
    chk("ch2_rise_c14", 64'(clean_out[2]), 1);
    chk("ch2_rise_pulse", 64'(rise_pulse), 64'h04);
    cyc();
    chk("ch2_rise_pulse_off", 64'(rise_pulse), 0);
    chk("ch2_clean_hold", 64'(clean_out), 64'h04);
    cycn(4);
    noisy_in[2] = 1'b0; push(2, 1'b0);
    cycn(13);
    chk("ch2_fall_early", 64'(clean_out[2]), 1);
    cyc();
    chk("ch2_fall_c14", 64'(clean_out[2]), 0);
    chk("ch2_fall_pulse", 64'(fall_pulse), 64'h04);
    cyc();
    chk("ch2_fall_pulse_off", 64'(fall_pulse), 0);
    cycn(4);

    // ch0 three-cycle bursts never survive a threshold of 10
    for (int b = 0; b < 4; b++) begin
      noisy_in[0] = 1'b1; cycn(3);
      noisy_in[0] = 1'b0; cycn(5);
      chk("burst_clean0", 64'(clean_out[0]), 0);
    end
    cycn(20);
    chk("burst_clean_all", 64'(clean_out), 0);
    chk("burst_no_evt", 64'(evt_valid), 0);
    chk("burst_sb_empty", 64'(exp_q.size()), 0);

    // simultaneous changes on 1,3,6 drain in round-robin order, one per cycle
    do_reset();
    cfg_threshold = 20'd2;
    noisy_in = 8'h4A; push(1, 1'b1); push(3, 1'b1); push(6, 1'b1);
    cycn(5);
    chk("rr_clean_early", 64'(clean_out), 0);
    cyc();
    chk("rr_clean", 64'(clean_out), 64'h4A);
    cyc();
    chk("rr_idle", 64'(evt_valid), 0);
    cyc();
    chk("rr_first", 64'({evt_valid, evt_ch}), 64'({1'b1, 3'd1}));
    cyc();
    chk("rr_second", 64'({evt_valid, evt_ch}), 64'({1'b1, 3'd3}));
    cyc();
    chk("rr_third", 64'({evt_valid, evt_ch}), 64'({1'b1, 3'd6}));
    cyc();
    chk("rr_drained", 64'(evt_valid), 0);
    chk("rr_sb_empty", 64'(exp_q.size()), 0);

    // ch4 toggles twice behind a stalled ch3 event: one event, final level, overflow
    noisy_in = '0;
    do_reset();
    cfg_threshold = 20'd0; evt_ready = 1'b0;
    noisy_in[3] = 1'b1; push(3, 1'b1);
    cycn(8);
    chk("ovf_block_ch", 64'({evt_valid, evt_ch}), 64'({1'b1, 3'd3}));
    noisy_in[4] = 1'b1;
    cycn(3);
    noisy_in[4] = 1'b0;
    cyc();
    chk("ovf_ch4_rise", 64'({clean_out[4], rise_pulse[4]}), 64'b11);
    cycn(3);
    chk("ovf_ch4_fall", 64'({clean_out[4], fall_pulse[4]}), 64'b01);
    chk("ovf_not_yet", 64'(ovf_flags), 0);
    cyc();
    chk("ovf_set", 64'(ovf_flags), 64'h10);
    push(4, 1'b0);
    cycn(2);
    chk("ovf_stable_payload", 64'({evt_valid, evt_ch, evt_level}), 64'({1'b1, 3'd3, 1'b1}));
    evt_ready = 1'b1;
    cyc();
    chk("ovf_next_evt", 64'({evt_valid, evt_ch, evt_level}), 64'({1'b1, 3'd4, 1'b0}));
    cyc();
    chk("ovf_drained", 64'(evt_valid), 0);
    chk("ovf_sticky", 64'(ovf_flags), 64'h10);
    ovf_clear = 8'h10;
    cyc();
    ovf_clear = '0;
    chk("ovf_cleared", 64'(ovf_flags), 0);

    // reset with ch5 mid-count and ch1 event pending
    noisy_in = '0;
    do_reset();
    cfg_threshold = 20'd10; evt_ready = 1'b0;
    noisy_in[1] = 1'b1; push(1, 1'b1);
    cycn(16);
    chk("mid_evt_valid", 64'({evt_valid, evt_ch}), 64'({1'b1, 3'd1}));
    noisy_in[5] = 1'b1;
    cycn(10);
    reset = 1'b1;
    exp_q.delete();
    cyc();
    chk("mid_rst_clean", 64'(clean_out), 0);
    chk("mid_rst_pulses", 64'({rise_pulse, fall_pulse}), 0);
    chk("mid_rst_evt", 64'({evt_valid, evt_ch, evt_level}), 0);
    chk("mid_rst_ovf", 64'(ovf_flags), 0);
    reset = 1'b0; evt_ready = 1'b1;
    push(1, 1'b1); push(5, 1'b1);
    cycn(13);
    chk("mid_restart_early", 64'(clean_out), 0);
    cyc();
    chk("mid_restart_clean", 64'(clean_out), 64'h22);
    chk("mid_restart_rise", 64'(rise_pulse), 64'h22);
    cycn(6);
    chk("mid_sb_empty", 64'(exp_q.size()), 0);

    // ch7 disabled through a stable change, then re-enabled
    noisy_in = '0;
    do_reset();
    cfg_threshold = 20'd5; ch_enable = 8'h7F;
    noisy_in[7] = 1'b1;
    cycn(20);
    chk("dis_clean", 64'(clean_out), 0);
    chk("dis_no_evt", 64'(evt_valid), 0);
    ch_enable = '1; push(7, 1'b1);
    cycn(6);
    chk("reen_early", 64'(clean_out[7]), 0);
    cyc();
    chk("reen_accept", 64'(clean_out[7]), 1);
    chk("reen_rise", 64'(rise_pulse), 64'h80);
    cycn(4);

    // lowering the threshold below a running count accepts on the next edge
    cfg_threshold = 20'd20;
    noisy_in[0] = 1'b1; push(0, 1'b1);
    cycn(12);
    chk("live_thr_early", 64'(clean_out[0]), 0);
    cfg_threshold = 20'd4;
    cyc();
    chk("live_thr_accept", 64'(clean_out[0]), 1);
    cycn(5);
    chk("final_sb_empty", 64'(exp_q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/multi_channel_debouncer.md
MULTI_CHANNEL_DEBOUNCER -- requirements
Module: multi_channel_debouncer

Interface
REQ-001 SHALL have parameter NUM_CH, default 8, number of independent input channels (1..32).
REQ-002 SHALL have parameter SYNC_STAGES, default 2, synchroniser depth per channel (>=2).
REQ-003 SHALL have parameter CNT_W, default 20, debounce counter and threshold width.
REQ-004 SHALL have port clk  input  1  system clock; single clock domain.
REQ-005 SHALL have port reset  input  1  synchronous active-high reset.
REQ-006 SHALL have port noisy_in  input  NUM_CH  asynchronous raw inputs.
REQ-007 SHALL have port ch_enable  input  NUM_CH  per-channel enable.
REQ-008 SHALL have port cfg_threshold  input  CNT_W  stable-cycle count required to accept a level.
REQ-009 SHALL have port clean_out  output  NUM_CH  debounced levels.
REQ-010 SHALL have ports rise_pulse and fall_pulse  output  NUM_CH  one-cycle edge strobes.
REQ-011 SHALL have ports evt_valid output 1, evt_ready input 1, evt_ch output clog2(NUM_CH), evt_level output 1  change-event stream.
REQ-012 SHALL have ports ovf_flags output NUM_CH (sticky lost-event flags) and ovf_clear input NUM_CH (per-bit clear).

Function
REQ-013 SHALL pass each noisy_in bit through SYNC_STAGES flops; last stage = sync_in.
REQ-014 Per channel SHALL keep candidate and counter: sync_in != candidate -> candidate <= sync_in, counter <= 0; else counter < cfg_threshold -> counter + 1; else clean != candidate -> clean <= candidate.
REQ-015 Latency pin-to-clean_out SHALL be SYNC_STAGES + cfg_threshold + 2 cycles for a stable input; cfg_threshold = 0 gives SYNC_STAGES + 2.
REQ-016 cfg_threshold SHALL be compared live; lowering it below a running count accepts on the next cycle.
REQ-017 Counter SHALL saturate at cfg_threshold; never wraps.
REQ-018 rise_pulse/fall_pulse SHALL assert for exactly the one cycle after clean_out changes 0->1 / 1->0.
REQ-019 ch_enable=0 SHALL freeze clean_out, hold counter at 0, keep candidate tracking sync_in, suppress pulses and events; re-enable restarts counting from 0.
REQ-020 Each clean_out change SHALL set that channel's pending bit and record the new level.
REQ-021 A change on a channel already pending SHALL overwrite the recorded level and set its ovf_flags bit.
REQ-022 Arbiter SHALL grant round-robin, starting search one index above the last granted channel, wrapping at NUM_CH-1.
REQ-023 evt_ch/evt_level SHALL be registered; evt_valid held with stable payload until evt_valid && evt_ready.
REQ-024 On handshake the granted pending bit SHALL clear, unless a new change on that channel occurs the same cycle: pending stays set, new level recorded, no overflow.
REQ-025 Next event SHALL be presentable the cycle after a handshake (one event per cycle max throughput).
REQ-026 ovf_clear SHALL clear ovf_flags bits; a simultaneous set wins.

Reset
REQ-027 Reset SHALL clear synchronisers, candidates, counters, clean_out, pulses, pending, ovf_flags, evt_valid, evt_ch, evt_level, round-robin pointer (first search starts at channel 0).
REQ-028 Reset mid-count or mid-handshake SHALL discard all state; no event emitted for the reset-induced level.

Structure
REQ-029 Shared package sig_cond_pkg SHALL hold default parameter constants and the channel-index width function.
REQ-030 One sub-module debounce_channel (synchroniser, candidate, counter, clean, pulses) SHALL be instantiated NUM_CH times; arbiter and event register live in the top.

Verification
REQ-031 Ch0 high-pulse bursts of 3 cycles, cfg_threshold=10 -> clean_out[0] stays 0, no events.
REQ-032 Ch2 steps 0->1, held, threshold=10, SYNC_STAGES=2 -> clean_out[2] rises at cycle 14, rise_pulse[2] one cycle, event {ch=2, level=1}.
REQ-033 Channels 1, 3, 6 change same cycle, evt_ready=1 -> events ordered 1, 3, 6 on consecutive cycles.
REQ-034 Ch4 toggles twice (threshold=0) with evt_ready=0 -> one event {ch=4, level=final}, ovf_flags[4]=1; ovf_clear[4] clears it.
REQ-035 Reset asserted while ch5 counter=7 and evt_valid=1 -> next cycle all outputs 0, counter 0.
REQ-036 ch_enable[7]=0 during a stable change -> no clean change, no event; re-enable -> acceptance threshold+2 cycles later.
